// File: rtl/perf_monitor.sv
// Performance monitor: cycle/instruction counters plus optional cache counters
// (define PERF_CACHE_CNT_EN to include them), read 16 bits at a time via a shadow.
module perf_monitor (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        retire,
  input  logic        halt,
  input  logic        dreq,
  input  logic        dhit,
  input  logic        ireq,
  input  logic        ihit,
  input  logic [3:0]  rd_sel,
  output logic [15:0] rd_data,
  output logic        halted,
  output logic        proto_err
);

  logic        clear_all;
  logic        cnt_en;
  logic [2:0]  rd_idx;
  logic [31:0] live_cnt;

  logic        halted_q, halted_d;
  logic [31:0] cyc_q, cyc_d;
  logic [31:0] inst_q, inst_d;
  logic [15:0] shadow_q, shadow_d;
  logic [2:0]  shadow_idx_q, shadow_idx_d;
  logic [15:0] rd_data_q, rd_data_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic inc);
    logic [31:0] res;
    if (inc && (val != 32'hFFFF_FFFF)) begin
      res = val + 32'd1;
    end else begin
      res = val;
    end
    return res;
  endfunction

  // rst and clr have identical effect, so a single wipe term covers both.
  assign clear_all = rst | clr;
  assign cnt_en    = ~halted_q;
  assign rd_idx    = rd_sel[3:1];

  // Core counters and the sticky halt flag
  always_comb begin
    cyc_d    = sat_inc(cyc_q, cnt_en);
    inst_d   = sat_inc(inst_q, cnt_en & retire);
    halted_d = halted_q | halt;
  end

  // Core state registers
  always_ff @(posedge clk) begin
    if (clear_all) begin
      cyc_q    <= 32'd0;
      inst_q   <= 32'd0;
      halted_q <= 1'b0;
    end else begin
      cyc_q    <= cyc_d;
      inst_q   <= inst_d;
      halted_q <= halted_d;
    end
  end

`ifdef PERF_CACHE_CNT_EN
  logic [31:0] dreq_q, dreq_d;
  logic [31:0] dhit_q, dhit_d;
  logic [31:0] ireq_q, ireq_d;
  logic [31:0] ihit_q, ihit_d;
  logic        proto_err_q, proto_err_d;

  // Hits only count alongside their request; a lone hit is a protocol error.
  always_comb begin
    dreq_d      = sat_inc(dreq_q, cnt_en & dreq);
    dhit_d      = sat_inc(dhit_q, cnt_en & dreq & dhit);
    ireq_d      = sat_inc(ireq_q, cnt_en & ireq);
    ihit_d      = sat_inc(ihit_q, cnt_en & ireq & ihit);
    proto_err_d = proto_err_q | (dhit & ~dreq) | (ihit & ~ireq);
  end

  // Cache counter registers
  always_ff @(posedge clk) begin
    if (clear_all) begin
      dreq_q      <= 32'd0;
      dhit_q      <= 32'd0;
      ireq_q      <= 32'd0;
      ihit_q      <= 32'd0;
      proto_err_q <= 1'b0;
    end else begin
      dreq_q      <= dreq_d;
      dhit_q      <= dhit_d;
      ireq_q      <= ireq_d;
      ihit_q      <= ihit_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign proto_err = proto_err_q;
`else
  logic unused_cache_inputs;
  assign unused_cache_inputs = ^{dreq, dhit, ireq, ihit};
  assign proto_err = 1'b0;
`endif

  // Counter select for the read port
  always_comb begin
    case (rd_idx)
      3'd0:    live_cnt = cyc_q;
      3'd1:    live_cnt = inst_q;
`ifdef PERF_CACHE_CNT_EN
      3'd2:    live_cnt = dreq_q;
      3'd3:    live_cnt = dhit_q;
      3'd4:    live_cnt = ireq_q;
      3'd5:    live_cnt = ihit_q;
`endif
      default: live_cnt = 32'd0;
    endcase
  end

  // Low-half reads latch the high half so a following high read is coherent.
  always_comb begin
    shadow_d     = shadow_q;
    shadow_idx_d = shadow_idx_q;
    rd_data_d    = live_cnt[15:0];
    if (!rd_sel[0]) begin
      shadow_d     = live_cnt[31:16];
      shadow_idx_d = rd_idx;
    end else if (rd_idx == shadow_idx_q) begin
      rd_data_d = shadow_q;
    end else begin
      rd_data_d = live_cnt[31:16];
    end
  end

  // Read port registers
  always_ff @(posedge clk) begin
    if (clear_all) begin
      shadow_q     <= 16'd0;
      shadow_idx_q <= 3'd0;
      rd_data_q    <= 16'd0;
    end else begin
      shadow_q     <= shadow_d;
      shadow_idx_q <= shadow_idx_d;
      rd_data_q    <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;
  assign halted  = halted_q;

endmodule

// File: tb/tb_perf_monitor.sv
// Scoreboard bench for perf_monitor: a reference model predicts every read,
// the prediction is queued when the read is issued and compared one edge later.
module tb_perf_monitor;

  logic        clk = 1'b0;
  logic        rst, clr, retire, halt, dreq, dhit, ireq, ihit;
  logic [3:0]  rd_sel;
  logic [15:0] rd_data;
  logic        halted, proto_err;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_q[$];
  logic [31:0] m_cnt [8];
  logic        m_halted, m_perr;
  logic [15:0] m_shadow;
  logic [2:0]  m_sidx;

`ifdef PERF_CACHE_CNT_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  // event vector bit order: {retire, halt, dreq, dhit, ireq, ihit}
  localparam logic [5:0] EV_NONE = 6'b000000;
  localparam logic [5:0] EV_RET  = 6'b100000;
  localparam logic [5:0] EV_HLT  = 6'b010000;
  localparam logic [5:0] EV_DRQ  = 6'b001000;
  localparam logic [5:0] EV_DHT  = 6'b000100;
  localparam logic [5:0] EV_IRQ  = 6'b000010;
  localparam logic [5:0] EV_IHT  = 6'b000001;
  localparam logic [5:0] EV_ALL  = 6'b111111;

  perf_monitor dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .retire    (retire),
    .halt      (halt),
    .dreq      (dreq),
    .dhit      (dhit),
    .ireq      (ireq),
    .ihit      (ihit),
    .rd_sel    (rd_sel),
    .rd_data   (rd_data),
    .halted    (halted),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_inc(input logic [31:0] v, input logic en);
    return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
  endfunction

  // Drive one cycle starting from a negedge, predict, then check after the posedge.
  task automatic step(input logic [5:0] ev, input logic c, input logic r, input logic [3:0] sel);
    logic [2:0]  idx;
    logic [31:0] live;
    logic [15:0] exp_rd;
    {retire, halt, dreq, dhit, ireq, ihit} = ev;
    clr    = c;
    rst    = r;
    rd_sel = sel;
    idx    = sel[3:1];
    live   = m_cnt[idx];
    if (r || c) begin
      exp_rd = 16'd0;
      for (int i = 0; i < 8; i++) m_cnt[i] = 32'd0;
      m_halted = 1'b0;
      m_perr   = 1'b0;
      m_shadow = 16'd0;
      m_sidx   = 3'd0;
    end else begin
      if (!sel[0]) begin
        exp_rd   = live[15:0];
        m_shadow = live[31:16];
        m_sidx   = idx;
      end else if (idx == m_sidx) begin
        exp_rd = m_shadow;
      end else begin
        exp_rd = live[31:16];
      end
      if (!m_halted) begin
        m_cnt[0] = m_inc(m_cnt[0], 1'b1);
        m_cnt[1] = m_inc(m_cnt[1], ev[5]);
        if (CACHE_EN) begin
          m_cnt[2] = m_inc(m_cnt[2], ev[3]);
          m_cnt[3] = m_inc(m_cnt[3], ev[3] & ev[2]);
          m_cnt[4] = m_inc(m_cnt[4], ev[1]);
          m_cnt[5] = m_inc(m_cnt[5], ev[1] & ev[0]);
        end
      end
      m_halted = m_halted | ev[4];
      if (CACHE_EN) m_perr = m_perr | (ev[2] & ~ev[3]) | (ev[0] & ~ev[1]);
    end
    exp_q.push_back(exp_rd);
    @(posedge clk);
    #1;
    check_eq("rd_data", {16'd0, rd_data}, {16'd0, exp_q.pop_front()});
    check_eq("halted", {31'd0, halted}, {31'd0, m_halted});
    check_eq("proto_err", {31'd0, proto_err}, {31'd0, m_perr});
    @(negedge clk);
  endtask

  // Coherent 32-bit read: low half then high half of the same index.
  task automatic rd32(input string tag, input logic [2:0] idx, input logic [31:0] exp);
    logic [15:0] lo, hi;
    step(EV_NONE, 1'b0, 1'b0, {idx, 1'b0});
    lo = rd_data;
    step(EV_NONE, 1'b0, 1'b0, {idx, 1'b1});
    hi = rd_data;
    check_eq(tag, {hi, lo}, exp);
  endtask

  initial begin
    {retire, halt, dreq, dhit, ireq, ihit} = EV_NONE;
    rst    = 1'b1;
    clr    = 1'b0;
    rd_sel = 4'd0;
    @(negedge clk);

    // reset, then 10 cycles with 4 retirements
    step(EV_NONE, 1'b0, 1'b1, 4'd0);
    check_eq("rst_rd", {16'd0, rd_data}, 32'd0);
    check_eq("rst_halted", {31'd0, halted}, 32'd0);
    for (int i = 0; i < 10; i++) step((i % 2 == 0 && i < 8) ? EV_RET : EV_NONE, 1'b0, 1'b0, 4'd2);
    rd32("cycles10", 3'd0, 32'd10);
    rd32("inst4", 3'd1, 32'd4);

    // data cache requests and hits
    step(EV_NONE, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 3; i++) step(EV_DRQ | EV_DHT, 1'b0, 1'b0, 4'd4);
    for (int i = 0; i < 2; i++) step(EV_DRQ, 1'b0, 1'b0, 4'd6);
    rd32("dreq5", 3'd2, CACHE_EN ? 32'd5 : 32'd0);
    rd32("dhit3", 3'd3, CACHE_EN ? 32'd3 : 32'd0);
    check_eq("perr_clean", {31'd0, proto_err}, 32'd0);

    // lone instruction hit
    step(EV_IHT, 1'b0, 1'b0, 4'd10);
    for (int i = 0; i < 5; i++) step(EV_NONE, 1'b0, 1'b0, 4'd11);
    rd32("ihit0", 3'd5, 32'd0);
    check_eq("perr_sticky", {31'd0, proto_err}, {31'd0, CACHE_EN});

    // shadow coherence across a low-half carry
    step(EV_NONE, 1'b1, 1'b0, 4'd0);
    force dut.cyc_q = 32'h0000_FFFF;
    #1;
    release dut.cyc_q;
    m_cnt[0] = 32'h0000_FFFF;
    step(EV_NONE, 1'b0, 1'b0, 4'b0000);
    check_eq("pre_lo", {16'd0, rd_data}, 32'h0000_FFFF);
    step(EV_NONE, 1'b0, 1'b0, 4'b0001);
    check_eq("shadow_hi", {16'd0, rd_data}, 32'h0000_0000);
    step(EV_NONE, 1'b0, 1'b0, 4'b0010);
    step(EV_NONE, 1'b0, 1'b0, 4'b0001);
    check_eq("live_hi", {16'd0, rd_data}, 32'h0000_0001);

    // halt at cycle 20; rst must win over a simultaneous halt
    step(EV_HLT, 1'b0, 1'b1, 4'd0);
    check_eq("rst_over_halt", {31'd0, halted}, 32'd0);
    for (int i = 0; i < 20; i++) step(EV_NONE, 1'b0, 1'b0, 4'd0);
    check_eq("pre_halt", {31'd0, halted}, 32'd0);
    step(EV_RET | EV_HLT, 1'b0, 1'b0, 4'd0);
    check_eq("halted_set", {31'd0, halted}, 32'd1);
    for (int i = 0; i < 10; i++) step(EV_RET | EV_DRQ | EV_IRQ, 1'b0, 1'b0, 4'd2);
    rd32("cycles21", 3'd0, 32'd21);
    rd32("inst_frozen", 3'd1, 32'd1);
    check_eq("halted_hold", {31'd0, halted}, 32'd1);

    // saturation, then clr with events in the same cycle for every index
    step(EV_NONE, 1'b1, 1'b0, 4'd0);
    force dut.inst_q = 32'hFFFF_FFFE;
    #1;
    release dut.inst_q;
    m_cnt[1] = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) step(EV_RET, 1'b0, 1'b0, 4'd0);
    rd32("inst_sat", 3'd1, 32'hFFFF_FFFF);
    for (int i = 0; i < 8; i++) begin
      step(EV_ALL, 1'b1, 1'b0, 4'd2);
      rd32($sformatf("clr_idx%0d", i), i[2:0], 32'd0);
    end
    check_eq("clr_halted", {31'd0, halted}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
